// File: rtl/pulse_pkg.sv
// Shared types and helpers for the pulse-sequencing controller.
package pulse_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_HIGH     = 2'd1;
  localparam logic [1:0] ST_REPORT   = 2'd2;
  localparam logic [1:0] ST_WAIT_LOW = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    HIGH     = ST_HIGH,
    REPORT   = ST_REPORT,
    WAIT_LOW = ST_WAIT_LOW
  } state_t;

  // Returns {out2, out1}: short pulses (len <= short_max) raise out1, all others out2.
  function automatic logic [1:0] pulse_class(input int unsigned len, input int unsigned short_max);
    logic is_short;
    is_short = (len <= short_max);
    return {~is_short, is_short};
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchroniser for an asynchronous input with rise/fall detection
// on the synchronised value.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   s_dly_q;
  logic                   s_dly_d;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], d};
    s_dly_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      s_dly_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      s_dly_q <= s_dly_d;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_dly_q;
  assign fall = ~s & s_dly_q;

endmodule

// File: rtl/pulse_seq_ctrl.sv
// Pulse-sequencing controller: measures synchronised inA high pulses, classifies
// them short/long and hands each event downstream over evt_valid/evt_ready.
//
// Handshake: evt_valid is high exactly while an event is pending; an event is
// consumed on a rising clk edge where evt_valid & evt_ready. evt_len/out1/out2
// are stable while evt_valid is high and return to 0 the cycle after consumption.
module pulse_seq_ctrl
  import pulse_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int SHORT_MAX   = 4,
  parameter int TIMEOUT     = 200,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inA,
  input  logic             enable,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] evt_len,
  output logic             out1,
  output logic             out2,
  output logic             busy,
  output logic             drop,
  output logic [1:0]       state_dbg
);

  logic s, rise, fall;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (inA),
    .s    (s),
    .rise (rise),
    .fall (fall)
  );

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             out1_q, out1_d;
  logic             out2_q, out2_d;
  logic             to_q, to_d;
  logic             drop_q, drop_d;
  logic [1:0]       cls;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    out1_d  = out1_q;
    out2_d  = out2_q;
    to_d    = to_q;
    drop_d  = drop_q;
    cls     = pulse_class(32'(cnt_q), SHORT_MAX);

    case (state_q)
      IDLE: begin
        if (enable && rise) begin
          state_d = HIGH;
          cnt_d   = CNT_W'(1);
        end
      end
      HIGH: begin
        // Disarming wins over a coincident fall or timeout.
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (fall) begin
          state_d          = REPORT;
          len_d            = cnt_q;
          {out2_d, out1_d} = cls;
          to_d             = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          state_d = REPORT;
          len_d   = CNT_W'(TIMEOUT);
          out1_d  = 1'b0;
          out2_d  = 1'b1;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REPORT: begin
        if (rise) drop_d = 1'b1;
        if (evt_ready) begin
          state_d = to_q ? WAIT_LOW : IDLE;
          cnt_d   = '0;
          len_d   = '0;
          out1_d  = 1'b0;
          out2_d  = 1'b0;
          to_d    = 1'b0;
        end
      end
      WAIT_LOW: begin
        if (!s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      out1_q  <= 1'b0;
      out2_q  <= 1'b0;
      to_q    <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      out1_q  <= out1_d;
      out2_q  <= out2_d;
      to_q    <= to_d;
      drop_q  <= drop_d;
    end
  end

  assign evt_valid = (state_q == REPORT);
  assign evt_len   = len_q;
  assign out1      = out1_q;
  assign out2      = out2_q;
  assign busy      = (state_q != IDLE);
  assign drop      = drop_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// Randomised scoreboard bench for pulse_seq_ctrl: expected events come from the
// pulse length alone; a monitor compares every presented event.
module tb_pulse_seq_ctrl;

  localparam int CNT_W     = 8;
  localparam int SHORT_MAX = 4;
  localparam int TIMEOUT   = 200;
  localparam int EW        = CNT_W + 2;

  // clock / reset / signals
  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             inA = 1'b0;
  logic             enable = 1'b0;
  logic             evt_ready = 1'b0;
  logic             evt_valid;
  logic [CNT_W-1:0] evt_len;
  logic             out1, out2, busy, drop;
  logic [1:0]       state_dbg;

  always #10 clk = ~clk;

  pulse_seq_ctrl #(
    .CNT_W(CNT_W), .SHORT_MAX(SHORT_MAX), .TIMEOUT(TIMEOUT), .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .inA      (inA),
    .enable   (enable),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_len  (evt_len),
    .out1     (out1),
    .out2     (out2),
    .busy     (busy),
    .drop     (drop),
    .state_dbg(state_dbg)
  );

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic exp_drop = 1'b0;
  int ready_mode = 0;  // 0 random, 1 hold low, 2 hold high

  // Reference: lengths beyond TIMEOUT clip to TIMEOUT and are always long.
  function automatic logic [EW-1:0] model(input int len);
    int   l;
    logic sh;
    l  = (len > TIMEOUT) ? TIMEOUT : len;
    sh = (l <= SHORT_MAX);
    return {CNT_W'(l), ~sh, sh};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (evt_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got len=%0d out1=%0b out2=%0b expected none at %0t",
                   evt_len, out1, out2, $time);
        end else begin
          check("evt_fields", 32'({evt_len, out2, out1}), 32'(exp_q[0]));
          if (evt_ready) void'(exp_q.pop_front());
        end
      end else begin
        check("idle_outputs_zero", 32'({evt_len, out2, out1}), 32'd0);
      end
    end
  end

  // consumer
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       evt_ready = 1'($urandom_range(0, 1));
      1:       evt_ready = 1'b0;
      default: evt_ready = 1'b1;
    endcase
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse(input int l);
    inA = 1'b1;
    cyc(l);
    inA = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(busy == 1'b0 && exp_q.size() == 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout: got busy=%0b pending=%0d expected idle", busy, exp_q.size());
    end
    cyc(2);
  endtask

  task automatic send(input int l);
    exp_q.push_back(model(l));
    pulse(l);
    wait_idle();
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!evt_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!evt_valid) begin
      errors++;
      $display("FAIL wait_valid_timeout: got evt_valid=0 expected 1");
    end
    #12;
  endtask

  initial begin
    int r, l;
    enable = 1'b1;
    #1 rst_n = 1'b0;
    cyc(3);
    check("rst_evt_valid", 32'(evt_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    check("rst_fields", 32'({evt_len, out2, out1}), 32'd0);
    rst_n = 1'b1;
    cyc(2);

    // directed: short, boundary, long, minimum, exactly TIMEOUT
    ready_mode = 2;
    send(3);
    send(SHORT_MAX);
    send(SHORT_MAX + 1);
    send(1);
    send(TIMEOUT);

    // randomised pulses with random consumer back-pressure
    ready_mode = 0;
    repeat (25) begin
      r = $urandom_range(0, 9);
      if (r < 7)      l = $urandom_range(1, 9);
      else if (r < 9) l = $urandom_range(TIMEOUT - 5, TIMEOUT + 5);
      else            l = $urandom_range(TIMEOUT + 10, TIMEOUT + 60);
      send(l);
      cyc($urandom_range(0, 4));
    end
    check("drop_after_random", 32'(drop), 32'(exp_drop));

    // timeout: one event only, busy held while pin stays high
    ready_mode = 2;
    exp_q.push_back(model(250));
    inA = 1'b1;
    cyc(240);
    check("timeout_busy_wait_low", 32'(busy), 32'd1);
    check("timeout_event_consumed", 32'(exp_q.size()), 32'd0);
    inA = 1'b0;
    wait_idle();
    check("timeout_busy_released", 32'(busy), 32'd0);

    // enable dropped mid-pulse, then pulse while disabled
    inA = 1'b1;
    cyc(5);
    check("abort_busy_before", 32'(busy), 32'd1);
    enable = 1'b0;
    cyc(1);
    check("abort_busy_after", 32'(busy), 32'd0);
    inA = 1'b0;
    cyc(4);
    pulse(4);
    cyc(6);
    check("disabled_busy", 32'(busy), 32'd0);
    check("disabled_drop", 32'(drop), 32'(exp_drop));
    enable = 1'b1;
    cyc(2);

    // back-pressure with a second pulse arriving while the event is pending
    ready_mode = 1;
    exp_q.push_back(model(9));
    pulse(9);
    wait_valid();
    pulse(3);
    cyc(8);
    exp_drop = 1'b1;
    check("drop_pending_busy", 32'(busy), 32'd1);
    ready_mode = 2;
    wait_idle();
    check("drop_set", 32'(drop), 32'(exp_drop));

    // asynchronous reset mid-pulse
    inA = 1'b1;
    cyc(6);
    check("reset_pre_busy", 32'(busy), 32'd1);
    #5 rst_n = 1'b0;
    #1;
    check("areset_busy", 32'(busy), 32'd0);
    check("areset_valid", 32'(evt_valid), 32'd0);
    check("areset_drop", 32'(drop), 32'd0);
    check("areset_fields", 32'({evt_len, out2, out1}), 32'd0);
    cyc(2);
    inA = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    exp_drop = 1'b0;
    cyc(2);
    send(2);
    check("final_drop", 32'(drop), 32'(exp_drop));
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
